l1_miss_ctrl: RTL and testbench
===============================

Name: l1_miss_ctrl

Overview:
Control half of the L1 cache: a 4-way x 32-set tag memory with valid bits, a per-set tree pseudo-LRU, and a 4-entry load miss queue (one entry per strand) that issues line fills to L2 and retires them. It sits between the core-side address pipeline and the L2 request/response interface. Data RAMs stay in the enclosing cache; this block supplies hit way, victim way and completion set/way to them.

Parameters:
UNIT_ID, 0, L2 unit number driven on pci_unit_o and matched against cpi_unit_i
NUM_SETS, 32, sets per way; set index is address_i[10:6]
TAG_WIDTH, 21, tag is address_i[31:11]

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
address_i  in  32  request address (cycle 0)
access_i  in  1  request valid (cycle 0)
strand_i  in  2  requesting strand (cycle 0)
synchronized_i  in  1  synchronized load (cycle 0)
cache_hit_o  out  1  cycle-1 hit
hit_way_o  out  2  cycle-1 hit way (0 on miss)
lru_way_o  out  2  cycle-1 victim way of latched set
load_collision_o  out  1  request collided with a completing fill; core must retry
load_complete_strands_o  out  4  strands woken by a fill this cycle
load_complete_set_o  out  5  set of completing fill
load_complete_way_o  out  2  way of completing fill
pci_valid_o  out  1  L2 request valid
pci_ack_i  in  1  L2 accepted request
pci_unit_o  out  2  =UNIT_ID
pci_strand_o  out  2  miss-queue entry index
pci_op_o  out  3  0=LOAD, 1=LOAD_SYNC
pci_way_o  out  2  victim way
pci_address_o  out  26  {tag,set}
cpi_valid_i  in  1  L2 response valid
cpi_unit_i  in  2  response unit
cpi_strand_i  in  2  response entry index

Behaviour:
- Reset: all valid bits 0, LRU bits 0, queue empty, all outputs 0.
- Pipeline: cycle 0 registers set, tag, strand, sync, access_i and the four tag/valid words of the set (read-before-write). In cycle 1, outputs are combinational from these registers.
- Hit = access_latched && some way valid with matching tag. cache_hit_o = hit && !sync_latched. Ways are never duplicated.
- LRU: 3 bits {b2,b1,b0} per set. lru_way = b0 ? {1,b2} : {0,b1}.
- On access_latched, touch way w (hit_way if hit, else lru_way): b0 <= ~w[1]; if w[1]=0 then b1 <= ~w[0], else b2 <= ~w[0].
- Miss queue entry: valid, issued, sync, tag, set, way, waiting-strand mask.
- Enqueue condition: access_latched && (!hit || sync_latched) && !load_collision_o.
  - If a valid entry holds the same {tag,set}: OR the strand bit into its mask (no new request).
  - Else: allocate entry[strand_latched] with way = (sync && hit) ? hit_way : lru_way and mask = 1<<strand.
  - A strand has at most one outstanding miss.
- Issue: round-robin over valid, un-issued entries (pointer advances past each accepted entry). pci_* are stable while pci_valid_o=1. The entry is marked issued in the cycle pci_ack_i=1.
- Completion: cpi_valid_i && cpi_unit_i==UNIT_ID && entry[cpi_strand_i] valid and issued.
  - Same cycle: load_complete_strands_o = entry mask; set/way outputs = entry's.
  - At the edge: tag memory writes {tag, valid} to that set/way; entry freed.
  - A response to an invalid entry is ignored.
- Collision: load_collision_o = registered (completion && its {tag,set} == cycle-0 request && access_i) OR (completion && {tag,set} == latched && access_latched). The LRU is still touched on a collision.
- Simultaneous merge-into-entry and completion of that entry: completion wins. The merging strand sees load_collision_o and retries.
- Reset mid-operation clears everything, including a pending pci_valid_o.

Test Plan:
- Cold miss: access 0x00001040, strand 1 -> cycle 1 cache_hit_o=0, lru_way_o=0; pci_valid_o=1, pci_address_o=0x000041, pci_op_o=0, pci_strand_o=1; after ack, cpi strand 1 -> load_complete_strands_o=4'b0010, way 0; re-access hits way 0.
- LRU fill: four distinct-tag misses to set 3 (each filled) -> victims 0,2,1,3; 5th miss after touching way 0 picks way 2.
- Merge: strands 0 and 2 miss the same line -> one pci request, completion mask 4'b0101.
- Collision: request the line on its completion cycle -> load_collision_o=1, no new pci request, next access hits.
- Sync hit: synchronized access to a resident line in way 2 -> cache_hit_o=0, pci_op_o=1, pci_way_o=2.
- Backpressure/reset: hold pci_ack_i=0 for 5 cycles -> pci fields stable; assert reset_n=0 -> pci_valid_o=0 and the next access misses.

Source files
------------

// File: rtl/l1_miss_ctrl.sv
// l1_miss_ctrl: L1 tag/valid/PLRU control with a 4-entry load miss queue feeding L2
module l1_miss_ctrl #(
  parameter int UNIT_ID   = 0,
  parameter int NUM_SETS  = 32,
  parameter int TAG_WIDTH = 21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        access_i,
  input  logic [1:0]  strand_i,
  input  logic        synchronized_i,
  output logic        cache_hit_o,
  output logic [1:0]  hit_way_o,
  output logic [1:0]  lru_way_o,
  output logic        load_collision_o,
  output logic [3:0]  load_complete_strands_o,
  output logic [4:0]  load_complete_set_o,
  output logic [1:0]  load_complete_way_o,
  output logic        pci_valid_o,
  input  logic        pci_ack_i,
  output logic [1:0]  pci_unit_o,
  output logic [1:0]  pci_strand_o,
  output logic [2:0]  pci_op_o,
  output logic [1:0]  pci_way_o,
  output logic [25:0] pci_address_o,
  input  logic        cpi_valid_i,
  input  logic [1:0]  cpi_unit_i,
  input  logic [1:0]  cpi_strand_i
);
  localparam int SW = $clog2(NUM_SETS);

  logic [TAG_WIDTH-1:0] tag_mem_q [4][NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q [4];
  logic [2:0]           lru_q [NUM_SETS];

  logic                 acc_q, sync_q, coll_q;
  logic [SW-1:0]        set_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [1:0]           strand_q;
  logic [TAG_WIDTH-1:0] wtag_q [4];
  logic [3:0]           wval_q;

  logic [3:0]           ev_q, ei_q, es_q;
  logic [TAG_WIDTH-1:0] et_q [4];
  logic [SW-1:0]        eset_q [4];
  logic [1:0]           ew_q [4];
  logic [3:0]           em_q [4];
  logic                 lock_q;
  logic [1:0]           lidx_q, rr_q;

  logic [SW-1:0]        req_set;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 hit, cpl, coll_now, enq, match, cand_ok;
  logic [1:0]           hway, lru_way, touch_way, midx, cand, ci, sel, cs;
  logic [2:0]           lru_cur, lru_nxt;
  logic [3:0]           sbit;
  logic                 unused_addr;

  assign req_set     = address_i[6 +: SW];
  assign req_tag     = address_i[31 -: TAG_WIDTH];
  assign unused_addr = ^address_i[5:0];
  assign cs          = cpi_strand_i;
  assign sbit        = 4'b0001 << strand_q;

  // Hit detection over the latched set; lowest matching way wins
  always_comb begin
    hit  = 1'b0;
    hway = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (acc_q && wval_q[i] && wtag_q[i] == tag_q) begin
        hit  = 1'b1;
        hway = 2'(i);
      end
  end

  assign lru_cur   = lru_q[set_q];
  assign lru_way   = lru_cur[0] ? {1'b1, lru_cur[2]} : {1'b0, lru_cur[1]};
  assign touch_way = hit ? hway : lru_way;
  assign lru_nxt   = {touch_way[1] ? ~touch_way[0] : lru_cur[2],
                      touch_way[1] ? lru_cur[1] : ~touch_way[0],
                      ~touch_way[1]};

  assign cpl      = cpi_valid_i && cpi_unit_i == 2'(UNIT_ID) && ev_q[cs] && ei_q[cs];
  assign coll_now = cpl && acc_q && {et_q[cs], eset_q[cs]} == {tag_q, set_q};

  assign cache_hit_o             = hit && !sync_q;
  assign hit_way_o               = hway;
  assign lru_way_o               = lru_way;
  assign load_collision_o        = coll_q || coll_now;
  assign load_complete_strands_o = cpl ? em_q[cs] : 4'd0;
  assign load_complete_set_o     = cpl ? eset_q[cs] : '0;
  assign load_complete_way_o     = cpl ? ew_q[cs] : 2'd0;

  assign enq = acc_q && (!hit || sync_q) && !load_collision_o;

  // Find an outstanding entry for the same line so the new strand can piggyback
  always_comb begin
    match = 1'b0;
    midx  = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (ev_q[i] && {et_q[i], eset_q[i]} == {tag_q, set_q}) begin
        match = 1'b1;
        midx  = 2'(i);
      end
  end

  // Round-robin pick of the next un-issued entry, first hit from rr_q onward
  always_comb begin
    cand_ok = 1'b0;
    cand    = 2'd0;
    ci      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      ci = rr_q + 2'(i);
      if (ev_q[ci] && !ei_q[ci]) begin
        cand_ok = 1'b1;
        cand    = ci;
      end
    end
  end

  assign sel           = lock_q ? lidx_q : cand;
  assign pci_valid_o   = lock_q || cand_ok;
  assign pci_unit_o    = 2'(UNIT_ID);
  assign pci_strand_o  = sel;
  assign pci_op_o      = {2'b00, es_q[sel]};
  assign pci_way_o     = ew_q[sel];
  assign pci_address_o = {et_q[sel], eset_q[sel]};

  // Cycle-0 capture: request fields plus the set's tag/valid words before any fill lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= 1'b0;
      sync_q   <= 1'b0;
      coll_q   <= 1'b0;
      set_q    <= '0;
      tag_q    <= '0;
      strand_q <= 2'd0;
      wval_q   <= 4'd0;
      for (int i = 0; i < 4; i++) wtag_q[i] <= '0;
    end else begin
      acc_q    <= access_i;
      sync_q   <= synchronized_i;
      set_q    <= req_set;
      tag_q    <= req_tag;
      strand_q <= strand_i;
      coll_q   <= cpl && access_i && {et_q[cs], eset_q[cs]} == {req_tag, req_set};
      for (int i = 0; i < 4; i++) begin
        wtag_q[i] <= tag_mem_q[i][req_set];
        wval_q[i] <= valid_q[i][req_set];
      end
    end
  end

  // Valid bits set by fills, PLRU touched by every latched access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) valid_q[i] <= '0;
      for (int s = 0; s < NUM_SETS; s++) lru_q[s] <= 3'd0;
    end else begin
      if (acc_q) lru_q[set_q] <= lru_nxt;
      if (cpl) valid_q[ew_q[cs]][eset_q[cs]] <= 1'b1;
    end
  end

  // Tag storage needs no reset; valid bits gate every use
  always_ff @(posedge clk)
    if (cpl) tag_mem_q[ew_q[cs]][eset_q[cs]] <= et_q[cs];

  // Miss queue: issue handshake, completion free, then merge or allocate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_q   <= 4'd0;
      ei_q   <= 4'd0;
      es_q   <= 4'd0;
      lock_q <= 1'b0;
      lidx_q <= 2'd0;
      rr_q   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        et_q[i]   <= '0;
        eset_q[i] <= '0;
        ew_q[i]   <= 2'd0;
        em_q[i]   <= 4'd0;
      end
    end else begin
      if (pci_valid_o && pci_ack_i) begin
        ei_q[sel] <= 1'b1;
        rr_q      <= sel + 2'd1;
        lock_q    <= 1'b0;
      end else if (pci_valid_o) begin
        lock_q <= 1'b1;
        lidx_q <= sel;
      end
      if (cpl) begin
        ev_q[cs] <= 1'b0;
        ei_q[cs] <= 1'b0;
      end
      if (enq && match) em_q[midx] <= em_q[midx] | sbit;
      else if (enq) begin
        ev_q[strand_q]   <= 1'b1;
        ei_q[strand_q]   <= 1'b0;
        es_q[strand_q]   <= sync_q;
        et_q[strand_q]   <= tag_q;
        eset_q[strand_q] <= set_q;
        ew_q[strand_q]   <= (sync_q && hit) ? hway : lru_way;
        em_q[strand_q]   <= sbit;
      end
    end
  end
endmodule

// File: tb/tb_l1_miss_ctrl.sv
// tb_l1_miss_ctrl: directed and random stimulus against a behavioural cache/miss-queue model
module tb_l1_miss_ctrl;
  logic        clk = 0, reset_n = 0;
  logic [31:0] address = 0;
  logic        access = 0, sync = 0, ack = 0, cv = 0;
  logic [1:0]  strand = 0, cu = 0, cs = 0;
  logic        cache_hit_o, load_collision_o, pci_valid_o;
  logic [1:0]  hit_way_o, lru_way_o, load_complete_way_o, pci_unit_o, pci_strand_o, pci_way_o;
  logic [3:0]  load_complete_strands_o;
  logic [4:0]  load_complete_set_o;
  logic [2:0]  pci_op_o;
  logic [25:0] pci_address_o;

  always #5 clk = ~clk;

  l1_miss_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address_i(address), .access_i(access), .strand_i(strand),
    .synchronized_i(sync), .cache_hit_o(cache_hit_o), .hit_way_o(hit_way_o), .lru_way_o(lru_way_o),
    .load_collision_o(load_collision_o), .load_complete_strands_o(load_complete_strands_o),
    .load_complete_set_o(load_complete_set_o), .load_complete_way_o(load_complete_way_o),
    .pci_valid_o(pci_valid_o), .pci_ack_i(ack), .pci_unit_o(pci_unit_o), .pci_strand_o(pci_strand_o),
    .pci_op_o(pci_op_o), .pci_way_o(pci_way_o), .pci_address_o(pci_address_o),
    .cpi_valid_i(cv), .cpi_unit_i(cu), .cpi_strand_i(cs)
  );

  int checks = 0, errors = 0;

  // model: cache contents, PLRU bits, latched request, miss queue, current L2 offer
  bit        mv [4][32];
  bit [20:0] mt [4][32];
  bit [2:0]  ml [32];
  bit        l_acc, l_sync, m_coll;
  bit [4:0]  l_set;
  bit [20:0] l_tag;
  bit [1:0]  l_str;
  bit        l_wv [4];
  bit [20:0] l_wt [4];
  bit        qv [4], qi [4], qs [4];
  bit [20:0] qt [4];
  bit [4:0]  qset [4];
  bit [1:0]  qw [4];
  bit [3:0]  qm [4];
  int        offer, rr;
  bit        e_hit, e_cpl, e_coll;
  bit [1:0]  e_hway, e_lru;

  function automatic bit [1:0] victim(input bit [2:0] b);
    return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction

  function automatic bit [2:0] touch(input bit [2:0] b, input bit [1:0] w);
    bit [2:0] r = b;
    r[0] = ~w[1];
    if (w[1]) r[2] = ~w[0]; else r[1] = ~w[0];
    return r;
  endfunction

  function automatic logic [31:0] mk(input int t, input int s);
    return (32'(t) << 11) | (32'(s) << 6);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 4; w++) for (int s = 0; s < 32; s++) begin mv[w][s] = 0; mt[w][s] = 0; end
    for (int s = 0; s < 32; s++) ml[s] = 0;
    l_acc = 0; l_sync = 0; m_coll = 0; l_set = 0; l_tag = 0; l_str = 0;
    for (int i = 0; i < 4; i++) begin
      l_wv[i] = 0; l_wt[i] = 0; qv[i] = 0; qi[i] = 0; qs[i] = 0; qt[i] = 0; qset[i] = 0; qw[i] = 0; qm[i] = 0;
    end
    offer = -1; rr = 0;
  endtask

  task automatic model_eval();
    e_hit = 0; e_hway = 0;
    for (int w = 0; w < 4; w++)
      if (!e_hit && l_acc && l_wv[w] && l_wt[w] == l_tag) begin e_hit = 1; e_hway = 2'(w); end
    e_lru  = victim(ml[l_set]);
    e_cpl  = cv && cu == 0 && qv[cs] && qi[cs];
    e_coll = m_coll || (e_cpl && l_acc && qt[cs] == l_tag && qset[cs] == l_set);
  endtask

  task automatic model_edge();
    bit [4:0] aset;
    bit [20:0] atag;
    bit found;
    if (!reset_n) begin model_reset(); return; end
    model_eval();
    aset = address[10:6];
    atag = address[31:11];
    if (l_acc) ml[l_set] = touch(ml[l_set], e_hit ? e_hway : e_lru);
    if (offer >= 0 && ack) begin qi[offer] = 1; rr = (offer + 1) % 4; offer = -1; end
    if (l_acc && (!e_hit || l_sync) && !e_coll) begin
      found = 0;
      for (int j = 0; j < 4; j++)
        if (!found && qv[j] && qt[j] == l_tag && qset[j] == l_set) begin found = 1; qm[j][l_str] = 1; end
      if (!found) begin
        qv[l_str] = 1; qi[l_str] = 0; qs[l_str] = l_sync; qt[l_str] = l_tag; qset[l_str] = l_set;
        qw[l_str] = (l_sync && e_hit) ? e_hway : e_lru;
        qm[l_str] = 4'b0001 << l_str;
      end
    end
    for (int w = 0; w < 4; w++) begin l_wv[w] = mv[w][aset]; l_wt[w] = mt[w][aset]; end
    m_coll = e_cpl && access && qt[cs] == atag && qset[cs] == aset;
    if (e_cpl) begin
      mv[qw[cs]][qset[cs]] = 1; mt[qw[cs]][qset[cs]] = qt[cs];
      if (!(l_acc && (!e_hit || l_sync) && !e_coll && l_str == cs)) begin qv[cs] = 0; qi[cs] = 0; end
    end
    l_acc = access; l_sync = sync; l_set = aset; l_tag = atag; l_str = strand;
    if (offer < 0)
      for (int k = 0; k < 4; k++)
        if (offer < 0 && qv[(rr + k) % 4] && !qi[(rr + k) % 4]) offer = (rr + k) % 4;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_();
    @(negedge clk);
    model_eval();
    chk("cache_hit", cache_hit_o, e_hit && !l_sync);
    chk("hit_way", hit_way_o, e_hway);
    chk("lru_way", lru_way_o, e_lru);
    chk("collision", load_collision_o, e_coll);
    chk("cpl_strands", load_complete_strands_o, e_cpl ? qm[cs] : 0);
    chk("cpl_set", load_complete_set_o, e_cpl ? qset[cs] : 0);
    chk("cpl_way", load_complete_way_o, e_cpl ? qw[cs] : 0);
    chk("pci_valid", pci_valid_o, offer >= 0);
    chk("pci_unit", pci_unit_o, 0);
    if (offer >= 0) begin
      chk("pci_strand", pci_strand_o, offer);
      chk("pci_op", pci_op_o, qs[offer]);
      chk("pci_way", pci_way_o, qw[offer]);
      chk("pci_addr", pci_address_o, {qt[offer], qset[offer]});
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input bit a, input logic [31:0] ad, input logic [1:0] s, input bit sy,
                     input bit ak, input bit c, input logic [1:0] cst);
    edge_();
    access = a; address = ad; strand = s; sync = sy; ack = ak; cv = c; cs = cst; cu = 0;
    check_();
  endtask

  task automatic rnd_cyc();
    bit [3:0] busy;
    int free_n, pick, iss_n;
    bit [1:0] free_l [4];
    bit [1:0] iss_l [4];
    int tags [6] = '{0, 1, 2, 3, 4, 5};
    int sets [2] = '{2, 17};
    edge_();
    busy = 0;
    for (int j = 0; j < 4; j++) if (qv[j]) busy |= qm[j];
    if (l_acc) busy[l_str] = 1;
    free_n = 0;
    for (int j = 0; j < 4; j++) if (!busy[j]) begin free_l[free_n] = 2'(j); free_n++; end
    access = free_n > 0 && $urandom_range(0, 2) != 0;
    pick = free_n > 0 ? $urandom_range(0, free_n - 1) : 0;
    strand = free_n > 0 ? free_l[pick] : 2'd0;
    address = mk(tags[$urandom_range(0, 5)], sets[$urandom_range(0, 1)]) | 32'($urandom_range(0, 63));
    sync = $urandom_range(0, 7) == 0;
    ack = 1'($urandom_range(0, 1));
    iss_n = 0;
    for (int j = 0; j < 4; j++) if (qv[j] && qi[j]) begin iss_l[iss_n] = 2'(j); iss_n++; end
    cv = $urandom_range(0, 2) == 0;
    cs = (iss_n > 0 && $urandom_range(0, 3) != 0) ? iss_l[$urandom_range(0, iss_n - 1)] : 2'($urandom_range(0, 3));
    cu = $urandom_range(0, 7) == 0 ? 2'd1 : 2'd0;
    check_();
  endtask

  initial begin
    int vict [4] = '{0, 2, 1, 3};
    model_reset();
    check_();
    chk("rst_hit", cache_hit_o, 0);
    chk("rst_pv", pci_valid_o, 0);
    chk("rst_strands", load_complete_strands_o, 0);
    chk("rst_addr", pci_address_o, 0);
    edge_();
    reset_n = 1;
    check_();

    // cold miss, fill, re-hit
    cyc(1, 32'h1040, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("cold_hit", cache_hit_o, 0);
    chk("cold_lru", lru_way_o, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("cold_pv", pci_valid_o, 1);
    chk("cold_addr", pci_address_o, 26'h41);
    chk("cold_op", pci_op_o, 0);
    chk("cold_str", pci_strand_o, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("cold_done", load_complete_strands_o, 4'b0010);
    chk("cold_way", load_complete_way_o, 0);
    cyc(1, 32'h1040, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("cold_rehit", cache_hit_o, 1);
    chk("cold_rehit_way", hit_way_o, 0);

    // PLRU victim order in set 3
    for (int k = 0; k < 4; k++) begin
      cyc(1, mk(10 + k, 3), 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("lru_victim", lru_way_o, vict[k]);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("lru_fill_way", load_complete_way_o, vict[k]);
    end
    cyc(1, mk(10, 3), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lru_touch_hit", hit_way_o, 0);
    cyc(1, mk(14, 3), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lru_fifth", lru_way_o, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // two strands merge onto one request
    cyc(1, mk(20, 5), 0, 0, 0, 0, 0);
    cyc(1, mk(20, 5), 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("merge_pv", pci_valid_o, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("merge_mask", load_complete_strands_o, 4'b0101);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("merge_one_req", pci_valid_o, 0);

    // request arrives in the fill's completion cycle
    cyc(1, mk(30, 7), 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, mk(30, 7), 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("coll_flag", load_collision_o, 1);
    cyc(1, mk(30, 7), 0, 0, 0, 0, 0);
    chk("coll_no_req", pci_valid_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("coll_retry_hit", cache_hit_o, 1);

    // synchronized load to a resident line in way 2
    cyc(1, mk(14, 3), 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sync_hit", cache_hit_o, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("sync_op", pci_op_o, 1);
    chk("sync_way", pci_way_o, 2);
    cyc(0, 0, 0, 0, 0, 1, 1);

    // backpressure then reset mid-request
    cyc(1, mk(40, 9), 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("bp_valid", pci_valid_o, 1);
      chk("bp_addr", pci_address_o, 26'h509);
      chk("bp_strand", pci_strand_o, 2);
    end
    edge_();
    reset_n = 0;
    model_reset();
    check_();
    chk("rst_mid_pv", pci_valid_o, 0);
    edge_();
    reset_n = 1;
    check_();
    cyc(1, 32'h1040, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_miss", cache_hit_o, 0);

    for (int n = 0; n < 4000; n++) rnd_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
